// File: rtl/disp_pkg.sv
// Shared types, default timing constants and small decode helpers for the
// multiplexed four-digit display scanner.
// Latency: n/a (types and pure functions only). Backpressure: n/a.
package disp_pkg;

    // Scan FSM: BLANK is the dead-time / dimmed part of a slot, ON drives a cathode.
    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] nibble_t;

    // Default slot length (CLOCK_50 cycles per digit) and dead time per slot.
    localparam int DISP_DIV   = 16384;
    localparam int DISP_BLANK = 256;

    // Active-low one-hot cathode pattern for a digit index.
    function automatic logic [3:0] cathode_n(input digit_idx_t idx);
        cathode_n = ~(4'b0001 << idx);
    endfunction

    // Nibble of the 16-bit display word belonging to a digit index.
    function automatic nibble_t nibble_sel(input logic [15:0] word, input digit_idx_t idx);
        nibble_sel = word[{idx, 2'b00} +: 4];
    endfunction

    // True when the digit and every more-significant digit are zero.
    // Digit 0 is never reported as a leading zero.
    function automatic logic lead_zero(input logic [15:0] word, input digit_idx_t idx);
        case (idx)
            2'd3:    lead_zero = (word[15:12] == 4'h0);
            2'd2:    lead_zero = (word[15:8]  == 8'h00);
            2'd1:    lead_zero = (word[15:4]  == 12'h000);
            default: lead_zero = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot timebase: free-running slot counter plus digit index and slot/frame strobes.
// Latency: strobes are combinational decodes of the registered counter.
// Backpressure: none; the counter runs every cycle and cannot be stalled.
//
// Ports:
//   CLOCK_50    in   system clock
//   reset_n     in   asynchronous active-low reset
//   cnt         out  position within the current slot, 0..DIV-1
//   digit_idx   out  digit currently being scanned, 0..3
//   slot_start  out  high while cnt == 0
//   slot_end    out  high while cnt == DIV-1
//   frame_end   out  high while cnt == DIV-1 on digit 3 (last cycle of a frame)
module scan_timer
    import disp_pkg::*;
#(
    parameter  int DIV   = DISP_DIV,
    localparam int CNT_W = $clog2(DIV)
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    output logic [CNT_W-1:0] cnt,
    output logic [1:0]       digit_idx,
    output logic             slot_start,
    output logic             slot_end,
    output logic             frame_end
);

    // DIV is a power of two, so the natural binary wrap gives DIV-1 -> 0.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            digit_idx <= 2'd0;
        end else begin
            cnt <= cnt + CNT_W'(1);
            if (slot_end) begin
                digit_idx <= digit_idx + 2'd1;
            end
        end
    end

    assign slot_start = (cnt == '0);
    assign slot_end   = (cnt == CNT_W'(DIV - 1));
    assign frame_end  = slot_end && (digit_idx == 2'd3);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with PWM brightness and tear-free updates.
// Latency: ct/num/frame_done are registered, one cycle behind the scan FSM/timebase.
// Backpressure: none; load is a fire-and-forget strobe, the latest load before a frame wins.
//
// Ports:
//   CLOCK_50    in   system clock
//   reset_n     in   asynchronous active-low reset
//   value[15:0] in   four BCD/hex digits, [3:0] = digit 0 (rightmost)
//   load        in   one-cycle strobe, captures value into the pending register
//   brightness  in   on-time level 0..7, sampled at each slot start
//   ct[3:0]     out  active-low one-hot digit cathodes, 4'b1111 = all dark
//   num[3:0]    out  nibble of the digit being scanned (to the segment decoder)
//   frame_done  out  one-cycle pulse when a new display word takes effect
//
// Build option: define LEADING_ZERO_BLANK_EN to keep leading-zero digits 3..1 dark.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DIV          = DISP_DIV,
    parameter int BLANK_CYCLES = DISP_BLANK
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [2:0]  brightness,
    output logic [3:0]  ct,
    output logic [3:0]  num,
    output logic        frame_done
);

    localparam int                CNT_W      = $clog2(DIV);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       digit_idx;
    logic             slot_start;
    logic             slot_end;
    logic             frame_end;

    logic [2:0]       phase;
    logic [2:0]       phase_nxt;
    logic [2:0]       bright_q;
    logic [15:0]      pend_reg;
    logic [15:0]      disp_reg;
    logic             digit_dark;
    scan_state_t      state;

    scan_timer #(
        .DIV (DIV)
    ) u_scan_timer (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .cnt        (cnt),
        .digit_idx  (digit_idx),
        .slot_start (slot_start),
        .slot_end   (slot_end),
        .frame_end  (frame_end)
    );

    // A slot is split into eight equal phases; brightness b keeps the digit lit
    // through phase b. The exit test looks at the phase of the next count so the
    // FSM is already BLANK on the first cycle of phase b+1, which makes the lit
    // window exactly (b+1)*DIV/8 - BLANK_CYCLES cycles long.
    assign cnt_nxt   = cnt + CNT_W'(1);
    assign phase     = cnt[CNT_W-1 -: 3];
    assign phase_nxt = cnt_nxt[CNT_W-1 -: 3];

`ifdef LEADING_ZERO_BLANK_EN
    // disp_reg only changes on a frame boundary, so this is stable for a whole slot.
    assign digit_dark = lead_zero(disp_reg, digit_idx);
`else
    assign digit_dark = 1'b0;
`endif

    // Pending/display double buffer: loads land in pend_reg at any time, the
    // display word only changes on the last cycle of digit 3 so a frame never
    // mixes two values. A load on that exact cycle bypasses pend_reg.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            pend_reg <= 16'h0000;
            disp_reg <= 16'h0000;
            bright_q <= 3'd0;
        end else begin
            if (load) begin
                pend_reg <= value;
            end
            if (frame_end) begin
                disp_reg <= load ? value : pend_reg;
            end
            // Mid-slot brightness changes wait for the next slot.
            if (slot_start) begin
                bright_q <= brightness;
            end
        end
    end

    // Scan FSM and registered outputs. Outputs are derived from the current
    // state, so the pins follow the FSM one cycle later. num tracks the digit in
    // both states so the segment data settles before its cathode turns on.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= BLANK;
            ct         <= 4'b1111;
            num        <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                BLANK: begin
                    if ((cnt == BLANK_LAST) && (phase <= bright_q)) begin
                        state <= ON;
                    end
                end
                ON: begin
                    if (slot_end || (phase_nxt > bright_q)) begin
                        state <= BLANK;
                    end
                end
                default: state <= BLANK;
            endcase

            ct         <= ((state == ON) && !digit_dark) ? cathode_n(digit_idx) : 4'b1111;
            num        <= nibble_sel(disp_reg, digit_idx);
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
module tb_disp_scan_ctrl;

    localparam int DIV   = 64;
    localparam int BLANK = 4;
    localparam int SLOT  = DIV;
    localparam int FRAME = 4 * DIV;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic [15:0] value;
    logic        load;
    logic [2:0]  brightness;
    logic [3:0]  ct;
    logic [3:0]  num;
    logic        frame_done;

    disp_scan_ctrl #(
        .DIV          (DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .value      (value),
        .load       (load),
        .brightness (brightness),
        .ct         (ct),
        .num        (num),
        .frame_done (frame_done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: cycles since reset release and the two value buffers.
    int          c;
    logic [15:0] m_pend;
    logic [15:0] m_disp;
    int          m_bq;

    // Aggregates collected over a window of cycles.
    int w_act [4];
    int w_bad_ct;
    int w_bad_num;
    int w_fd;

    typedef struct {
        logic [2:0]  bright;
        logic [15:0] val;
        int          on_cyc;
        logic [3:0]  shown;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, c);
    endtask

    task automatic model_reset();
        c      = 0;
        m_pend = 16'h0000;
        m_disp = 16'h0000;
        m_bq   = 0;
    endtask

    function automatic bit lz_dark(input logic [15:0] w, input int d);
        if (!LZB || d == 0) return 1'b0;
        return (w >> (4 * d)) == 16'h0000;
    endfunction

    // One clock: predict the outputs that the edge ending cycle c produces,
    // advance the model, clock the DUT and compare.
    task automatic step();
        int         p;
        int         d;
        int         endp;
        bit         on;
        logic [3:0] e_ct;
        logic [3:0] e_num;
        bit         e_fd;
        p = c % SLOT;
        d = (c / SLOT) % 4;
        if (p == 0) m_bq = brightness;
        endp  = (m_bq == 7) ? SLOT : (m_bq + 1) * SLOT / 8;
        on    = (p >= BLANK) && (p < endp) && !lz_dark(m_disp, d);
        e_ct  = on ? ~(4'b0001 << d) : 4'b1111;
        e_num = m_disp[4*d +: 4];
        e_fd  = (p == SLOT - 1) && (d == 3);
        if (p == SLOT - 1 && d == 3) m_disp = load ? value : m_pend;
        if (load) m_pend = value;
        c++;
        @(posedge CLOCK_50);
        #1;
        chk("ct", ct, e_ct);
        chk("num", num, e_num);
        chk("frame_done", frame_done, e_fd);
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic run_to(input int modulus, input int target);
        while (c % modulus != target) step();
    endtask

    task automatic do_reset(input int ncyc, input bit load_during);
        reset_n = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            if (load_during) begin
                value = 16'hFFFF;
                load  = 1'b1;
            end
            @(posedge CLOCK_50);
            #1;
            chk("rst_ct", ct, 4'b1111);
            chk("rst_num", num, 4'h0);
            chk("rst_frame_done", frame_done, 0);
        end
        load    = 1'b0;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic first_enable();
        int         first;
        logic [3:0] first_ct;
        first    = -1;
        first_ct = 4'b1111;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (first < 0 && ct != 4'b1111) begin
                first    = k;
                first_ct = ct;
            end
        end
        chk("first_enable_cycle", first, 5);
        chk("first_enable_ct", first_ct, 4'b1110);
    endtask

    task automatic scan_window(input int nsteps, input logic [15:0] exp_val);
        int hit;
        for (int d = 0; d < 4; d++) w_act[d] = 0;
        w_bad_ct  = 0;
        w_bad_num = 0;
        w_fd      = 0;
        for (int i = 0; i < nsteps; i++) begin
            step();
            if (frame_done) w_fd++;
            if (ct != 4'b1111) begin
                hit = -1;
                for (int d = 0; d < 4; d++) if (ct == ~(4'b0001 << d)) hit = d;
                if (hit < 0) w_bad_ct++;
                else begin
                    w_act[hit]++;
                    if (num != exp_val[4*hit +: 4]) w_bad_num++;
                end
            end
        end
    endtask

    // Expects to be called on a frame start.
    task automatic measure_frame(input logic [15:0] exp_val, input int on_cyc,
                                 input logic [3:0] shown, input int id);
        scan_window(FRAME, exp_val);
        for (int d = 0; d < 4; d++)
            chk($sformatf("vec%0d_on_digit%0d", id, d), w_act[d], shown[d] ? on_cyc : 0);
        chk($sformatf("vec%0d_bad_ct", id), w_bad_ct, 0);
        chk($sformatf("vec%0d_num", id), w_bad_num, 0);
        chk($sformatf("vec%0d_frame_done", id), w_fd, 1);
    endtask

    initial begin
        vecs[0] = '{3'd7, 16'h1234, 60, 4'b1111};
        vecs[1] = '{3'd0, 16'h1234, 4,  4'b1111};
        vecs[2] = '{3'd3, 16'h5A0F, 28, 4'b1111};
        vecs[3] = '{3'd6, 16'h0050, 52, LZB ? 4'b0011 : 4'b1111};
        vecs[4] = '{3'd1, 16'h0000, 12, LZB ? 4'b0001 : 4'b1111};
        vecs[5] = '{3'd7, 16'h0700, 60, LZB ? 4'b0111 : 4'b1111};

        reset_n    = 1'b0;
        load       = 1'b0;
        value      = 16'h0000;
        brightness = 3'd7;
        model_reset();

        // Reset held 10 cycles with a load pulse that must be lost.
        do_reset(10, 1'b1);
        first_enable();

        // Table-driven scans: load, wait for the frame boundary, measure a frame.
        for (int i = 0; i < 6; i++) begin
            brightness = vecs[i].bright;
            pulse_load(vecs[i].val);
            run_to(FRAME, 0);
            measure_frame(vecs[i].val, vecs[i].on_cyc, vecs[i].shown, i);
        end

        // Brightness change in the middle of a slot waits for the next slot.
        begin
            int on_cnt;
            brightness = 3'd7;
            run_to(FRAME, 0);
            on_cnt = 0;
            for (int i = 0; i < SLOT; i++) begin
                if (i == 10) brightness = 3'd0;
                step();
                if (ct == 4'b1110) on_cnt++;
            end
            chk("midslot_bright_same_slot", on_cnt, 60);
            on_cnt = 0;
            for (int i = 0; i < SLOT; i++) begin
                step();
                if (ct == 4'b1101) on_cnt++;
            end
            chk("midslot_bright_next_slot", on_cnt, 4);
        end

        // Tear-free update: load while digit 1 is lit.
        brightness = 3'd7;
        pulse_load(16'h1234);
        run_to(FRAME, 0);
        run_to(FRAME, SLOT + 10);
        chk("tear_pre_ct", ct, 4'b1101);
        pulse_load(16'hABCD);
        scan_window(FRAME - (c % FRAME), 16'h1234);
        chk("tear_old_num", w_bad_num, 0);
        chk("tear_old_active", (w_act[1] + w_act[2] + w_act[3]) > 0, 1);
        measure_frame(16'hABCD, 60, 4'b1111, 10);

        // Latest load wins, and a load on the boundary cycle shows next frame.
        run_to(FRAME, 100);
        pulse_load(16'h9999);
        run_to(FRAME, FRAME - 1);
        pulse_load(16'h5678);
        measure_frame(16'h5678, 60, 4'b1111, 11);

        // Reset during digit 2's lit interval.
        run_to(FRAME, 2 * SLOT + 20);
        chk("midrst_pre_ct", ct, 4'b1011);
        reset_n = 1'b0;
        #1;
        chk("midrst_ct_now", ct, 4'b1111);
        chk("midrst_num_now", num, 4'h0);
        chk("midrst_fd_now", frame_done, 0);
        do_reset(4, 1'b0);
        first_enable();

        // Random loads and brightness changes against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                value = 16'($urandom);
                if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
                load = 1'b1;
            end
            if ($urandom_range(0, 49) == 0) brightness = 3'($urandom_range(0, 7));
            step();
            load = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
